// File: rtl/operand_forward_unit.sv
// Operand select and bypass for the issue stage: tracks two in-flight destination tags,
// forwards mem/wb results, and refuses issue for one cycle on a load-use hazard.
module operand_forward_unit #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_W-1:0]  rs1,
    input  logic [REG_W-1:0]  rs2,
    input  logic [REG_W-1:0]  rd,
    input  logic              rd_we,
    input  logic              is_load,
    input  logic              use_pc,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              flush,
    output logic [DATA_W-1:0] op1,
    output logic [DATA_W-1:0] op2,
    output logic              op_valid,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             we;
        logic             ld;
    } tag_t;

    tag_t s1, s2;

    logic              m1_s1, m1_s2, m2_s1, m2_s2;
    logic              accept;
    logic [DATA_W-1:0] fwd1, fwd2, sel1, sel2;

    always_comb begin
        m1_s1 = s1.we && (s1.rd == rs1) && (rs1 != '0);
        m1_s2 = s2.we && (s2.rd == rs1) && (rs1 != '0);
        m2_s1 = s1.we && (s1.rd == rs2) && (rs2 != '0);
        m2_s2 = s2.we && (s2.rd == rs2) && (rs2 != '0);

        // A load in S1 has no data yet; once it reaches S2 its value is on wb_result.
        stall  = !rst && issue_valid && !flush && s1.ld &&
                 ((!use_pc && m1_s1) || (!use_imm && m2_s1));
        accept = issue_valid && !stall && !flush;

        fwd1 = rd1;
        if (m1_s1 && !s1.ld) fwd1 = mem_result;
        else if (m1_s2)      fwd1 = wb_result;

        fwd2 = rd2;
        if (m2_s1 && !s1.ld) fwd2 = mem_result;
        else if (m2_s2)      fwd2 = wb_result;

        sel1 = use_pc  ? pc  : fwd1;
        sel2 = use_imm ? imm : fwd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            op1       <= '0;
            op2       <= '0;
            op_valid  <= 1'b0;
            stall_cnt <= '0;
        end else if (flush) begin
            s1       <= '0;
            s2       <= '0;
            op_valid <= 1'b0;
        end else begin
            s2       <= s1;
            s1       <= accept ? tag_t'{rd: rd, we: rd_we, ld: is_load} : tag_t'('0);
            op_valid <= accept;
            if (accept) begin
                op1 <= sel1;
                op2 <= sel2;
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_forward_unit.sv
// Bench for operand_forward_unit: directed vector table, stall-counter saturation
// sequence, then randomized traffic checked against a producer-search reference model.
module tb_operand_forward_unit;

    localparam int DW = 32;
    localparam int RW = 4;
    localparam int CW = 4;

    localparam logic [31:0] PC  = 32'h0000_4000;
    localparam logic [31:0] IMM = 32'h0000_00FF;
    localparam logic [31:0] A   = 32'h0000_AAAA;
    localparam logic [31:0] B   = 32'h0000_1234;
    localparam logic [31:0] R10 = 32'h1000_0000;
    localparam logic [31:0] R20 = 32'h2000_0000;

    logic          clk = 1'b0;
    logic          rst, issue_valid, rd_we, is_load, use_pc, use_imm, flush;
    logic [RW-1:0] rs1, rs2, rd;
    logic [DW-1:0] rd1, rd2, imm, pc, mem_result, wb_result;
    logic [DW-1:0] op1, op2;
    logic          op_valid, stall;
    logic [CW-1:0] stall_cnt;

    always #5 clk = ~clk;

    operand_forward_unit #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .rs1(rs1), .rs2(rs2),
        .rd(rd), .rd_we(rd_we), .is_load(is_load), .use_pc(use_pc), .use_imm(use_imm),
        .rd1(rd1), .rd2(rd2), .imm(imm), .pc(pc), .mem_result(mem_result),
        .wb_result(wb_result), .flush(flush), .op1(op1), .op2(op2),
        .op_valid(op_valid), .stall(stall), .stall_cnt(stall_cnt)
    );

    typedef struct {
        bit          rst, iv, we, ld, upc, uimm, flush;
        logic [3:0]  rs1, rs2, rd;
        logic [31:0] rd1, rd2, imm, pc, mem, wb;
    } in_t;

    typedef struct {
        in_t         i;
        bit          xs, xov, cop;
        logic [31:0] x1, x2;
        int          cnt;
    } vec_t;

    typedef struct {
        logic [3:0] rd;
        bit         we, ld;
    } tag_t;

    int errs = 0;
    int checks = 0;

    // Reference model: history of the last two issue slots, youngest first.
    tag_t        hist[2];
    bit          m_stall, m_ov;
    logic [31:0] m_op1, m_op2;
    int          m_cnt;
    bit          s_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int producer(input logic [3:0] r);
        if (r == 0) return -1;
        for (int k = 0; k < 2; k++)
            if (hist[k].we && hist[k].rd == r) return k;
        return -1;
    endfunction

    function automatic logic [31:0] src_val(input logic [3:0] r, input logic [31:0] rf, input in_t x);
        case (producer(r))
            0:       return x.mem;
            1:       return x.wb;
            default: return rf;
        endcase
    endfunction

    function automatic bit load_hazard(input logic [3:0] r);
        return producer(r) == 0 && hist[0].ld;
    endfunction

    task automatic model_pre(input in_t x);
        m_stall = !x.rst && x.iv && !x.flush &&
                  ((!x.upc && load_hazard(x.rs1)) || (!x.uimm && load_hazard(x.rs2)));
    endtask

    task automatic model_post(input in_t x);
        bit acc;
        if (x.rst) begin
            hist[0] = '{0, 0, 0}; hist[1] = '{0, 0, 0};
            m_op1 = 0; m_op2 = 0; m_ov = 0; m_cnt = 0;
        end else if (x.flush) begin
            hist[0] = '{0, 0, 0}; hist[1] = '{0, 0, 0};
            m_ov = 0;
        end else begin
            acc = x.iv && !m_stall;
            if (acc) begin
                m_op1 = x.upc  ? x.pc  : src_val(x.rs1, x.rd1, x);
                m_op2 = x.uimm ? x.imm : src_val(x.rs2, x.rd2, x);
            end
            m_ov = acc;
            if (m_stall && m_cnt < (1 << CW) - 1) m_cnt++;
            hist[1] = hist[0];
            hist[0] = acc ? tag_t'{x.rd, x.we, x.ld} : tag_t'{0, 0, 0};
        end
    endtask

    // Drives one cycle: inputs at negedge, stall sampled before the edge,
    // registered outputs observed #1 after the rising edge.
    task automatic run_cycle(input in_t x);
        @(negedge clk);
        rst = x.rst; issue_valid = x.iv; rs1 = x.rs1; rs2 = x.rs2; rd = x.rd;
        rd_we = x.we; is_load = x.ld; use_pc = x.upc; use_imm = x.uimm; flush = x.flush;
        rd1 = x.rd1; rd2 = x.rd2; imm = x.imm; pc = x.pc; mem_result = x.mem; wb_result = x.wb;
        #1;
        model_pre(x);
        s_stall = stall;
        @(posedge clk);
        #1;
        model_post(x);
    endtask

    function automatic vec_t mk(input bit r, iv, input logic [3:0] s1, s2, d,
                                input bit we, ld, upc, uimm, fl, input logic [31:0] mem, wb,
                                input bit xs, xov, cop, input logic [31:0] x1, x2, input int cnt);
        vec_t v;
        v.i.rst = r; v.i.iv = iv; v.i.rs1 = s1; v.i.rs2 = s2; v.i.rd = d;
        v.i.we = we; v.i.ld = ld; v.i.upc = upc; v.i.uimm = uimm; v.i.flush = fl;
        v.i.rd1 = R10 | 32'(s1); v.i.rd2 = R20 | 32'(s2);
        v.i.imm = IMM; v.i.pc = PC; v.i.mem = mem; v.i.wb = wb;
        v.xs = xs; v.xov = xov; v.cop = cop; v.x1 = x1; v.x2 = x2; v.cnt = cnt;
        return v;
    endfunction

    vec_t tbl[$];
    in_t  ri;

    initial begin
        hist[0] = '{0, 0, 0}; hist[1] = '{0, 0, 0};
        m_op1 = 0; m_op2 = 0; m_ov = 0; m_cnt = 0;
        rst = 1; issue_valid = 0; rs1 = 0; rs2 = 0; rd = 0; rd_we = 0; is_load = 0;
        use_pc = 0; use_imm = 0; flush = 0; rd1 = 0; rd2 = 0; imm = 0; pc = 0;
        mem_result = 0; wb_result = 0;

        //           rst iv rs1 rs2 rd we ld pc im fl mem    wb     | xs ov cop x1      x2      cnt
        tbl.push_back(mk(1, 1, 0, 0, 3, 1, 0, 0, 0, 0, A, B,         0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 3, 1, 0, 0, 0, 0, A, B,         0, 1, 1, R10, R20, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, A, B,         0, 1, 1, A, R20, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, A, B,         0, 0, 1, A, R20, 0));
        tbl.push_back(mk(0, 1, 0, 0, 5, 1, 1, 0, 0, 0, A, B,         0, 1, 1, R10, R20, 0));
        tbl.push_back(mk(0, 1, 0, 5, 6, 1, 0, 0, 0, 0, A, B,         1, 0, 1, R10, R20, 1));
        tbl.push_back(mk(0, 1, 0, 5, 6, 1, 0, 0, 0, 0, A, B,         0, 1, 1, R10, B, 1));
        tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, A, B,         0, 1, 1, R10, R20, 1));
        tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0, 0, A, B,         0, 1, 1, R10, R20, 1));
        tbl.push_back(mk(0, 1, 7, 0, 7, 1, 0, 0, 0, 0, 32'h11, 32'h22, 0, 1, 1, 32'h11, R20, 1));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, A, B,         0, 1, 1, R10, R20, 1));
        tbl.push_back(mk(0, 1, 0, 0, 9, 1, 1, 0, 0, 0, A, B,         0, 1, 1, R10, R20, 1));
        tbl.push_back(mk(0, 1, 9, 9, 0, 0, 0, 1, 1, 0, A, B,         0, 1, 1, PC, IMM, 1));
        tbl.push_back(mk(0, 1, 0, 0, 5, 1, 1, 0, 0, 0, A, B,         0, 1, 1, R10, R20, 1));
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 1, A, B,         0, 0, 1, R10, R20, 1));
        tbl.push_back(mk(0, 1, 5, 5, 5, 1, 1, 0, 0, 0, A, B,         0, 1, 1, R10 | 5, R20 | 5, 1));
        tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, A, B,         0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 5, 0, 0, 0, 0, 0, 0, 0, A, B,         0, 0, 1, 0, 0, 0));

        foreach (tbl[n]) begin
            run_cycle(tbl[n].i);
            chk($sformatf("vec%0d stall", n), 32'(s_stall), 32'(tbl[n].xs));
            chk($sformatf("vec%0d op_valid", n), 32'(op_valid), 32'(tbl[n].xov));
            chk($sformatf("vec%0d stall_cnt", n), 32'(stall_cnt), 32'(tbl[n].cnt));
            if (tbl[n].cop) begin
                chk($sformatf("vec%0d op1", n), op1, tbl[n].x1);
                chk($sformatf("vec%0d op2", n), op2, tbl[n].x2);
            end
        end

        // Repeated load-use pairs drive the 4-bit stall counter into saturation.
        for (int k = 1; k <= 20; k++) begin
            run_cycle(mk(0, 1, 0, 0, 5, 1, 1, 0, 0, 0, A, B, 0, 0, 0, 0, 0, 0).i);
            chk("sat load op_valid", 32'(op_valid), 32'd1);
            run_cycle(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, A, B, 0, 0, 0, 0, 0, 0).i);
            chk("sat stall", 32'(s_stall), 32'd1);
            chk("sat stall_cnt", 32'(stall_cnt), 32'((k < 15) ? k : 15));
        end

        for (int n = 0; n < 400; n++) begin
            ri.rst   = ($urandom_range(0, 99) < 2);
            ri.iv    = ($urandom_range(0, 9) < 8);
            ri.flush = ($urandom_range(0, 99) < 5);
            ri.we    = ($urandom_range(0, 9) < 8);
            ri.ld    = ($urandom_range(0, 9) < 4);
            ri.upc   = ($urandom_range(0, 9) < 2);
            ri.uimm  = ($urandom_range(0, 9) < 2);
            ri.rs1   = 4'($urandom_range(0, 7));
            ri.rs2   = 4'($urandom_range(0, 7));
            ri.rd    = 4'($urandom_range(0, 7));
            ri.rd1 = $urandom; ri.rd2 = $urandom; ri.imm = $urandom; ri.pc = $urandom;
            ri.mem = $urandom; ri.wb = $urandom;
            run_cycle(ri);
            chk("rand stall", 32'(s_stall), 32'(m_stall));
            chk("rand op_valid", 32'(op_valid), 32'(m_ov));
            chk("rand op1", op1, m_op1);
            chk("rand op2", op2, m_op2);
            chk("rand stall_cnt", 32'(stall_cnt), 32'(m_cnt));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
